// File: rtl/syscall_print_unit.sv
// Print-integer syscall responder: queues $a0 on each Print_a0 rising edge,
// converts it to signed decimal with double-dabble and sends it on a UART 8N1 line.
module syscall_print_unit #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4,
   parameter int NEWLINE      = 1
) (
   input  logic        real_clk,
   input  logic        rst,
   input  logic        Print_a0,
   input  logic [31:0] a0_value,
   output logic        tx,
   output logic        busy,
   output logic        overrun
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST      = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   FIFO_FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CONVERT, S_EMIT, S_START, S_DATA, S_STOP
   } state_t;

   state_t        state_q, state_d;
   logic          prev_a0_q, prev_a0_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [31:0]   value_q, value_d;
   logic [31:0]   mag_q, mag_d;
   logic [39:0]   bcd_q, bcd_d;
   logic [4:0]    cnv_cnt_q, cnv_cnt_d;
   logic          sign_pend_q, sign_pend_d;
   logic          dig_started_q, dig_started_d;
   logic          dig_done_q, dig_done_d;
   logic [3:0]    dig_idx_q, dig_idx_d;
   logic          nl_pend_q, nl_pend_d;
   logic [7:0]    char_q, char_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic          overrun_q, overrun_d;

   logic [31:0]   fifo_mem [FIFO_DEPTH];
   logic [AW:0]   count_q, count_d;
   logic          fifo_empty, fifo_full;
   logic          push_req, push_acc, pop;
   logic [31:0]   fifo_rd;

   logic [39:0]   bcd_adj;
   logic [71:0]   dd_shifted;
   logic [9:0]    digit_nz;
   logic [3:0]    msd;
   logic [3:0]    cur_idx;
   logic [3:0]    cur_digit;
   logic          nothing_left_d;

   assign count_q    = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FIFO_FULL_CNT);
   assign fifo_rd    = fifo_mem[rd_ptr_q[AW-1:0]];

   // Each BCD digit is corrected before the shift so it carries correctly.
   generate
      for (genvar gi = 0; gi < 10; gi++) begin : g_digit
         assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ? (bcd_q[gi*4 +: 4] + 4'd3)
                                                                : bcd_q[gi*4 +: 4];
         assign digit_nz[gi] = |bcd_q[gi*4 +: 4];
      end
   endgenerate

   assign dd_shifted = {bcd_adj, mag_q} << 1;

   always_comb begin
      msd = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (digit_nz[i]) msd = 4'(i);
      end
   end

   assign cur_idx   = dig_started_q ? dig_idx_q : msd;
   assign cur_digit = bcd_q[{cur_idx, 2'b00} +: 4];

   always_comb begin
      state_d       = state_q;
      value_d       = value_q;
      mag_d         = mag_q;
      bcd_d         = bcd_q;
      cnv_cnt_d     = cnv_cnt_q;
      sign_pend_d   = sign_pend_q;
      dig_started_d = dig_started_q;
      dig_done_d    = dig_done_q;
      dig_idx_d     = dig_idx_q;
      nl_pend_d     = nl_pend_q;
      char_d        = char_q;
      bit_idx_d     = bit_idx_q;
      clk_cnt_d     = clk_cnt_q;
      tx_d          = tx_q;
      pop           = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               value_d = fifo_rd;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            mag_d         = value_q[31] ? (~value_q + 32'd1) : value_q;
            bcd_d         = '0;
            cnv_cnt_d     = '0;
            sign_pend_d   = value_q[31];
            dig_started_d = 1'b0;
            dig_done_d    = 1'b0;
            dig_idx_d     = '0;
            nl_pend_d     = (NEWLINE != 0);
            state_d       = S_CONVERT;
         end
         S_CONVERT: begin
            bcd_d     = dd_shifted[71:32];
            mag_d     = dd_shifted[31:0];
            cnv_cnt_d = cnv_cnt_q + 5'd1;
            if (cnv_cnt_q == 5'd31) state_d = S_EMIT;
         end
         S_EMIT: begin
            clk_cnt_d = '0;
            if (sign_pend_q) begin
               char_d      = 8'h2D;
               sign_pend_d = 1'b0;
               tx_d        = 1'b0;
               state_d     = S_START;
            end else if (!dig_done_q) begin
               char_d        = {4'h3, cur_digit};
               dig_started_d = 1'b1;
               if (cur_idx == 4'd0) dig_done_d = 1'b1;
               else                 dig_idx_d  = cur_idx - 4'd1;
               tx_d    = 1'b0;
               state_d = S_START;
            end else if (nl_pend_q) begin
               char_d    = 8'h0A;
               nl_pend_d = 1'b0;
               tx_d      = 1'b0;
               state_d   = S_START;
            end else if (!fifo_empty) begin
               pop     = 1'b1;
               value_d = fifo_rd;
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               bit_idx_d = 3'd0;
               tx_d      = char_q[0];
               state_d   = S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = char_q[bit_idx_q + 3'd1];
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (clk_cnt_q == BIT_LAST) begin
               clk_cnt_d = '0;
               state_d   = S_EMIT;
            end else begin
               clk_cnt_d = clk_cnt_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   always_comb begin
      prev_a0_d = Print_a0;
      push_req  = Print_a0 & ~prev_a0_q;
      push_acc  = push_req & (~fifo_full | pop);
      wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push_acc};
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
      count_d   = wr_ptr_d - rd_ptr_d;
      overrun_d = overrun_q | (push_req & ~push_acc);
   end

   // busy drops as the final stop bit ends, one cycle ahead of the EMIT->IDLE step.
   always_comb begin
      nothing_left_d = ~sign_pend_d & dig_done_d & ~nl_pend_d;
      busy_d = (count_d != '0) |
               ~((state_d == S_IDLE) | ((state_d == S_EMIT) & nothing_left_d));
   end

   always_ff @(posedge real_clk) begin
      if (push_acc) fifo_mem[wr_ptr_q[AW-1:0]] <= a0_value;
   end

   always_ff @(posedge real_clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         prev_a0_q     <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         value_q       <= '0;
         mag_q         <= '0;
         bcd_q         <= '0;
         cnv_cnt_q     <= '0;
         sign_pend_q   <= 1'b0;
         dig_started_q <= 1'b0;
         dig_done_q    <= 1'b0;
         dig_idx_q     <= '0;
         nl_pend_q     <= 1'b0;
         char_q        <= '0;
         bit_idx_q     <= '0;
         clk_cnt_q     <= '0;
         tx_q          <= 1'b1;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_a0_q     <= prev_a0_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         value_q       <= value_d;
         mag_q         <= mag_d;
         bcd_q         <= bcd_d;
         cnv_cnt_q     <= cnv_cnt_d;
         sign_pend_q   <= sign_pend_d;
         dig_started_q <= dig_started_d;
         dig_done_q    <= dig_done_d;
         dig_idx_q     <= dig_idx_d;
         nl_pend_q     <= nl_pend_d;
         char_q        <= char_d;
         bit_idx_q     <= bit_idx_d;
         clk_cnt_q     <= clk_cnt_d;
         tx_q          <= tx_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule
